// File: rtl/mux2_sel_arbiter_if.sv
// mux2_sel_arbiter_if: two source streams, the merged stream and the mux select
interface mux2_sel_arbiter_if #(parameter int WIDTH = 8);
  logic             a_valid, a_last, a_ready;
  logic             b_valid, b_last, b_ready;
  logic             y_valid, y_last, y_ready;
  logic             sel, forced;
  logic [WIDTH-1:0] a_data, b_data, y_data;
  modport master (
    output a_valid, a_data, a_last, b_valid, b_data, b_last, y_ready,
    input  a_ready, b_ready, sel, y_valid, y_data, y_last, forced
  );
  modport slave (
    input  a_valid, a_data, a_last, b_valid, b_data, b_last, y_ready,
    output a_ready, b_ready, sel, y_valid, y_data, y_last, forced
  );
endinterface

// File: rtl/mux2_sel_arbiter.sv
// mux2_sel_arbiter: packet-level round-robin merge of two streams with a beat watchdog
module mux2_sel_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic             clk,
  input logic             rst,
  mux2_sel_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] CLAST = CW'(MAX_BEATS - 1);
  localparam logic [1:0] IDLE = 2'd0, GRANT_A = 2'd1, GRANT_B = 2'd2;
  logic [1:0]    state;
  logic          prio;
  logic [CW-1:0] cnt;
  logic          acc, rel, pick_b;
  assign bus.y_valid = state == GRANT_A ? bus.a_valid : state == GRANT_B ? bus.b_valid : 1'b0;
  assign bus.y_data  = WIDTH'(bus.sel ? bus.b_data : bus.a_data);
  assign bus.y_last  = bus.sel ? bus.b_last : bus.a_last;
  assign bus.a_ready = (state == GRANT_A) & bus.y_ready;
  assign bus.b_ready = (state == GRANT_B) & bus.y_ready;
  assign acc    = bus.y_valid & bus.y_ready;
  assign rel    = acc & (bus.y_last | cnt == CLAST);
  assign pick_b = bus.b_valid & (~bus.a_valid | prio);
  // sel only moves on IDLE->GRANT, so it is stable whenever y_valid can be high
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus.sel    <= 1'b0;
      prio       <= 1'b0;
      cnt        <= '0;
      bus.forced <= 1'b0;
    end else begin
      bus.forced <= rel & ~bus.y_last;
      if (state == IDLE) begin
        if (bus.a_valid | bus.b_valid) begin
          state   <= pick_b ? GRANT_B : GRANT_A;
          bus.sel <= pick_b;
          cnt     <= '0;
        end
      end else begin
        if (acc) cnt <= cnt + 1'b1;
        if (rel) begin
          state <= IDLE;
          prio  <= ~bus.sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// tb_mux2_sel_arbiter: directed scenarios with queue-driven sources and an output scoreboard
module tb_mux2_sel_arbiter;
  localparam int MB = 4;
  typedef struct {logic [7:0] data; logic last; int gap;} beat_t;
  typedef struct {logic [7:0] data; logic last; logic sel;} exp_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  mux2_sel_arbiter_if #(.WIDTH(8)) ifc();
  mux2_sel_arbiter #(.WIDTH(8), .MAX_BEATS(MB)) dut (.clk(clk), .rst(rst), .bus(ifc));
  beat_t sq [2][$];
  exp_t  exq [$];
  int    gap [2] = '{-1, -1};
  logic  fire [2];
  int    tests = 0, fails = 0, nb = 0, fcnt = 0;
  logic  fexp = 0, bub = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic push(input int s, input logic [7:0] d, input logic l, input int g);
    sq[s].push_back('{d, l, g});
  endtask
  task automatic pkt(input int s, input logic [7:0] d0, input int n);
    for (int i = 0; i < n; i++) push(s, 8'(d0 + i), i == n - 1, 0);
  endtask
  task automatic ex(input logic [7:0] d, input logic l, input logic s);
    exq.push_back('{d, l, s});
  endtask
  task automatic expkt(input logic [7:0] d0, input int n, input logic s);
    for (int i = 0; i < n; i++) ex(8'(d0 + i), i == n - 1, s);
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exq.size() > 0; i++) tick();
    chk(tag, exq.size(), 0);
  endtask
  // source driver: holds the queue head until the handshake seen before the edge completes
  initial begin
    logic       vld [2];
    logic [7:0] dat [2];
    logic       lst [2];
    ifc.a_valid = 0; ifc.a_data = 0; ifc.a_last = 0;
    ifc.b_valid = 0; ifc.b_data = 0; ifc.b_last = 0;
    forever begin
      @(negedge clk);
      fire[0] = ifc.a_valid && ifc.a_ready && !rst;
      fire[1] = ifc.b_valid && ifc.b_ready && !rst;
      @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
        if (fire[s]) begin
          void'(sq[s].pop_front());
          gap[s] = -1;
        end
        vld[s] = 0; dat[s] = 0; lst[s] = 0;
        if (sq[s].size() > 0) begin
          if (gap[s] < 0) gap[s] = sq[s][0].gap;
          if (gap[s] > 0) gap[s]--;
          else begin
            vld[s] = 1;
            dat[s] = sq[s][0].data;
            lst[s] = sq[s][0].last;
          end
        end
      end
      ifc.a_valid = vld[0]; ifc.a_data = dat[0]; ifc.a_last = lst[0];
      ifc.b_valid = vld[1]; ifc.b_data = dat[1]; ifc.b_last = lst[1];
    end
  end
  // output monitor: scoreboard pop, forced pulse model and post-release bubble
  always @(negedge clk) begin
    logic acc;
    exp_t e;
    if (rst) begin
      nb = 0; fexp = 0; bub = 0;
    end else begin
      chk("forced", ifc.forced, fexp);
      if (ifc.forced) fcnt++;
      if (bub) chk("bubble", ifc.y_valid, 0);
      acc  = ifc.y_valid && ifc.y_ready;
      fexp = acc && !ifc.y_last && nb == MB - 1;
      bub  = acc && (ifc.y_last || nb == MB - 1);
      if (acc) begin
        if (exq.size() == 0) chk("extra_beat", exq.size(), 1);
        else begin
          e = exq.pop_front();
          chk("y_data", ifc.y_data, e.data);
          chk("y_last", ifc.y_last, e.last);
          chk("sel", ifc.sel, e.sel);
        end
        nb = bub ? 0 : nb + 1;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ifc.y_ready = 1;
    rst = 1;
    push(0, 8'h01, 1, 0);
    push(1, 8'h02, 1, 0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst_sel", ifc.sel, 0);
    chk("rst_y_valid", ifc.y_valid, 0);
    chk("rst_a_ready", ifc.a_ready, 0);
    chk("rst_b_ready", ifc.b_ready, 0);
    tick();
    rst = 0;
    ex(8'h01, 1, 0);
    ex(8'h02, 1, 1);
    drain("rst_drain");
    pkt(0, 8'h11, 3); pkt(1, 8'h21, 3); pkt(0, 8'h11, 3);
    expkt(8'h11, 3, 0); expkt(8'h21, 3, 1); expkt(8'h11, 3, 0);
    drain("fair_drain");
    ifc.y_ready = 0;
    pkt(0, 8'h41, 3);
    expkt(8'h41, 3, 0);
    tick(); tick(); tick();
    pkt(1, 8'h51, 1);
    ex(8'h51, 1, 1);
    for (int i = 0; i < 5; i++) begin
      ifc.y_ready = (i % 2 == 0);
      @(negedge clk);
      chk("bp_a_ready", ifc.a_ready, (i % 2 == 0));
      chk("bp_b_ready", ifc.b_ready, 0);
      tick();
    end
    ifc.y_ready = 1;
    drain("bp_drain");
    fcnt = 0;
    for (int i = 0; i < 6; i++) push(0, 8'(8'h61 + i), 0, 0);
    push(0, 8'h67, 1, 0);
    push(1, 8'h71, 1, 0);
    for (int i = 0; i < 4; i++) ex(8'(8'h61 + i), 0, 0);
    ex(8'h71, 1, 1);
    ex(8'h65, 0, 0); ex(8'h66, 0, 0); ex(8'h67, 1, 0);
    drain("wd_drain");
    chk("wd_forced_count", fcnt, 1);
    push(1, 8'h81, 1, 0);
    ex(8'h81, 1, 1);
    drain("prio_drain");
    push(0, 8'h91, 0, 0); push(0, 8'h92, 0, 5); push(0, 8'h93, 1, 0);
    push(1, 8'hA1, 1, 0);
    expkt(8'h91, 3, 0);
    ex(8'hA1, 1, 1);
    for (int i = 0; i < 50 && sq[0].size() != 2; i++) tick();
    chk("stall_reach", sq[0].size(), 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_sel", ifc.sel, 0);
      chk("stall_y_valid", ifc.y_valid, 0);
      chk("stall_b_ready", ifc.b_ready, 0);
      tick();
    end
    drain("stall_drain");
    pkt(1, 8'hB1, 3);
    ex(8'hB1, 0, 1);
    for (int i = 0; i < 50 && sq[1].size() != 2; i++) tick();
    chk("mid_reach", sq[1].size(), 2);
    rst = 1;
    push(0, 8'hC1, 1, 0);
    tick();
    @(negedge clk);
    chk("mid_sel", ifc.sel, 0);
    chk("mid_y_valid", ifc.y_valid, 0);
    chk("mid_b_ready", ifc.b_ready, 0);
    chk("mid_state", dut.state, 0);
    chk("mid_prio", dut.prio, 0);
    tick();
    rst = 0;
    ex(8'hC1, 1, 0);
    ex(8'hB2, 0, 1);
    ex(8'hB3, 1, 1);
    drain("mid_drain");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
